// File: rtl/fb_pkg.sv
// Shared constants, types and helpers for the framebuffer scheduler slice.
package fb_pkg;

  localparam int unsigned FB_W     = 160;
  localparam int unsigned FB_H     = 120;
  localparam int unsigned SCALE    = 4;
  localparam int unsigned COLOR_W  = 8;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned SCALE_SH = $clog2(SCALE);

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_TOTAL  = 525;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [ADDR_W:0]    fb_addr_t;

  typedef enum logic {
    RUN,
    SWAP_WAIT
  } sched_state_e;

  // Linear index of FB pixel (col,row) within one bank.
  function automatic logic [ADDR_W-1:0] fb_index(logic [ADDR_W-1:0] row,
                                                 logic [ADDR_W-1:0] col);
    return row * ADDR_W'(FB_W) + col;
  endfunction

endpackage

// File: rtl/raster_lookahead.sv
// Raster position two pixel clocks ahead of the beam, wrapping at line and frame ends.
module raster_lookahead import fb_pkg::*; (
  input  logic [9:0] sx_in,
  input  logic [9:0] sy_in,
  output logic [9:0] nx_out,
  output logic [9:0] ny_out
);

  localparam int unsigned Ahead = 2;

  // Advance x by Ahead; on line wrap step y, wrapping at the last frame line.
  always_comb begin
    nx_out = sx_in + 10'(Ahead);
    ny_out = sy_in;
    if (sx_in >= 10'(H_TOTAL - Ahead)) begin
      nx_out = sx_in - 10'(H_TOTAL - Ahead);
      ny_out = (sy_in == 10'(V_TOTAL - 1)) ? 10'd0 : sy_in + 10'd1;
    end
  end

endmodule

// File: rtl/fb_scheduler.sv
// Single-port framebuffer arbiter: display fetches ahead of the beam, renderer writes in
// free cycles, and double-buffer swaps sequenced at the first vblank pixel.
module fb_scheduler import fb_pkg::*; (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [9:0]         sx_in,
  input  logic [9:0]         sy_in,
  input  logic               wr_valid_in,
  output logic               wr_ready_out,
  input  logic [7:0]         wr_x_in,
  input  logic [6:0]         wr_y_in,
  input  logic [COLOR_W-1:0] wr_color_in,
  input  logic               swap_req_in,
  output logic               swap_done_out,
  output logic               front_buf_out,
  output logic               fb_en_out,
  output logic               fb_we_out,
  output logic [ADDR_W:0]    fb_addr_out,
  output logic [COLOR_W-1:0] fb_wdata_out,
  input  logic [COLOR_W-1:0] fb_rdata_in,
  output logic [COLOR_W-1:0] pixel_out
);

  logic [9:0]         w_nx;
  logic [9:0]         w_ny;
  logic               w_read_slot;
  logic               w_wr_accept;
  logic               w_wr_in_range;
  logic [ADDR_W-1:0]  w_rd_index;
  logic [ADDR_W-1:0]  w_wr_index;

  sched_state_e       r_state;
  logic               r_front;
  logic               r_swap_done;
  logic               r_rd_pend;
  logic [COLOR_W-1:0] r_pixel;

  raster_lookahead u_lookahead (
    .sx_in  (sx_in),
    .sy_in  (sy_in),
    .nx_out (w_nx),
    .ny_out (w_ny)
  );

  assign w_read_slot = (w_nx < 10'(H_ACTIVE)) && (w_ny < 10'(V_ACTIVE)) &&
                       ((w_nx % 10'(SCALE)) == 10'd0);
  assign w_rd_index  = fb_index(ADDR_W'(w_ny >> SCALE_SH), ADDR_W'(w_nx >> SCALE_SH));
  assign w_wr_index  = fb_index(ADDR_W'(wr_y_in), ADDR_W'(wr_x_in));

  // Ready is held low in reset so no handshake completes while the RAM port is idle.
  assign wr_ready_out  = !rst_in && (r_state == RUN) && !w_read_slot;
  assign w_wr_accept   = wr_valid_in && wr_ready_out;
  assign w_wr_in_range = (wr_x_in < 8'(FB_W)) && (wr_y_in < 7'(FB_H));

  assign swap_done_out = r_swap_done;
  assign front_buf_out = r_front;
  assign pixel_out     = ((sx_in < 10'(H_ACTIVE)) && (sy_in < 10'(V_ACTIVE))) ? r_pixel : '0;

  // RAM port mux: display reads win; accepted in-range writes target the back bank.
  always_comb begin
    fb_en_out    = 1'b0;
    fb_we_out    = 1'b0;
    fb_addr_out  = '0;
    fb_wdata_out = '0;
    if (!rst_in) begin
      if (w_read_slot) begin
        fb_en_out   = 1'b1;
        fb_addr_out = {r_front, w_rd_index};
      end else if (w_wr_accept && w_wr_in_range) begin
        fb_en_out    = 1'b1;
        fb_we_out    = 1'b1;
        fb_addr_out  = {~r_front, w_wr_index};
        fb_wdata_out = wr_color_in;
      end
    end
  end

  // Swap FSM: latch a request, then flip banks on the first vblank pixel.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= RUN;
      r_front     <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= 1'b0;
      case (r_state)
        RUN: begin
          if (swap_req_in) r_state <= SWAP_WAIT;
        end
        SWAP_WAIT: begin
          if ((sx_in == 10'd0) && (sy_in == 10'(V_ACTIVE))) begin
            r_front     <= ~r_front;
            r_swap_done <= 1'b1;
            r_state     <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Read pipeline: capture RAM data the cycle after a fetch, hold until the next fetch.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rd_pend <= 1'b0;
      r_pixel   <= '0;
    end else begin
      r_rd_pend <= w_read_slot;
      if (r_rd_pend) r_pixel <= fb_rdata_in;
    end
  end

endmodule

// File: tb/tb_fb_scheduler.sv
// Bench for fb_scheduler: raster driven directly, RAM returns the low address bits as data.
module tb_fb_scheduler;
  import fb_pkg::*;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic [9:0]         sx_in;
  logic [9:0]         sy_in;
  logic               wr_valid_in;
  logic               wr_ready_out;
  logic [7:0]         wr_x_in;
  logic [6:0]         wr_y_in;
  logic [COLOR_W-1:0] wr_color_in;
  logic               swap_req_in;
  logic               swap_done_out;
  logic               front_buf_out;
  logic               fb_en_out;
  logic               fb_we_out;
  logic [ADDR_W:0]    fb_addr_out;
  logic [COLOR_W-1:0] fb_wdata_out;
  logic [COLOR_W-1:0] fb_rdata_in;
  logic [COLOR_W-1:0] pixel_out;

  always #5 clk_in = ~clk_in;

  fb_scheduler u_dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .sx_in         (sx_in),
    .sy_in         (sy_in),
    .wr_valid_in   (wr_valid_in),
    .wr_ready_out  (wr_ready_out),
    .wr_x_in       (wr_x_in),
    .wr_y_in       (wr_y_in),
    .wr_color_in   (wr_color_in),
    .swap_req_in   (swap_req_in),
    .swap_done_out (swap_done_out),
    .front_buf_out (front_buf_out),
    .fb_en_out     (fb_en_out),
    .fb_we_out     (fb_we_out),
    .fb_addr_out   (fb_addr_out),
    .fb_wdata_out  (fb_wdata_out),
    .fb_rdata_in   (fb_rdata_in),
    .pixel_out     (pixel_out)
  );

  // RAM model: synchronous read returning the low address bits.
  always @(posedge clk_in) begin
    if (fb_en_out && !fb_we_out) fb_rdata_in <= fb_addr_out[COLOR_W-1:0];
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int cx, cy;
  bit m_front, m_wait, m_done;

  function automatic bit exp_read(int x, int y);
    int q, nx, ny;
    q  = (y * 800 + x + 2) % (800 * 525);
    nx = q % 800;
    ny = q / 800;
    return (nx < 640) && (ny < 480) && (nx % 4 == 0);
  endfunction

  function automatic logic [15:0] exp_raddr(bit bank, int x, int y);
    int q, nx, ny;
    q  = (y * 800 + x + 2) % (800 * 525);
    nx = q % 800;
    ny = q / 800;
    return {bank, 15'((ny / 4) * 160 + nx / 4)};
  endfunction

  function automatic logic [7:0] exp_pixel(int x, int y);
    if (x < 640 && y < 480) return 8'(((y / 4) * 160 + x / 4));
    return 8'd0;
  endfunction

  task automatic goto(int x, int y);
    cx    = x;
    cy    = y;
    sx_in = 10'(x);
    sy_in = 10'(y);
  endtask

  // Apply this cycle's inputs to the model, clock, then advance the raster.
  task automatic step();
    int lin;
    m_done = 1'b0;
    if (rst_in) begin
      m_front = 1'b0;
      m_wait  = 1'b0;
    end else if (!m_wait) begin
      if (swap_req_in) m_wait = 1'b1;
    end else if (cx == 0 && cy == 480) begin
      m_front = !m_front;
      m_wait  = 1'b0;
      m_done  = 1'b1;
    end
    @(posedge clk_in);
    #1;
    lin = (cy * 800 + cx + 1) % (800 * 525);
    goto(lin % 800, lin / 800);
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    goto(0, 0);
    for (int i = 0; i < 6; i++) begin
      #3;
      n_checks++;
      if (fb_en_out !== 1'b0 || fb_we_out !== 1'b0 || wr_ready_out !== 1'b0)
        $display("FAIL reset_port: en=%b we=%b rdy=%b want 0 0 0",
                 fb_en_out, fb_we_out, wr_ready_out);
      else n_pass++;
      if (i >= 1) begin
        n_checks++;
        if (front_buf_out !== 1'b0 || swap_done_out !== 1'b0 || pixel_out !== 8'd0)
          $display("FAIL reset_state: front=%b done=%b pix=%0h want 0 0 0",
                   front_buf_out, swap_done_out, pixel_out);
        else n_pass++;
      end
      step();
    end
    rst_in = 1'b0;
    goto(790, 524);
    while (!(cx == 2 && cy == 0)) begin
      #3;
      n_checks++;
      if (fb_en_out !== exp_read(cx, cy) || fb_we_out !== 1'b0)
        $display("FAIL first_read_en @%0d,%0d: en=%b we=%b want %b 0",
                 cx, cy, fb_en_out, fb_we_out, exp_read(cx, cy));
      else n_pass++;
      if (cx == 798) begin
        n_checks++;
        if (fb_addr_out !== 16'h0000)
          $display("FAIL first_read_addr: got %0h want 0", fb_addr_out);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_pixels();
    int reads3 = 0;
    int guard  = 0;
    goto(780, 524);
    while (!(cx == 5 && cy == 8) && guard < 8000) begin
      #3;
      guard++;
      if (cy == 3 && fb_en_out && !fb_we_out) reads3++;
      if ((cx == 4 && cy == 0) || (cx == 640 && cy == 0) || (cx == 636 && cy == 4) ||
          (cx == 0 && cy == 8) || (cx == 323 && cy == 5)) begin
        n_checks++;
        if (pixel_out !== exp_pixel(cx, cy))
          $display("FAIL pixel @%0d,%0d: got %0d want %0d", cx, cy, pixel_out,
                   exp_pixel(cx, cy));
        else n_pass++;
      end
      step();
    end
    n_checks++;
    if (reads3 != 160) $display("FAIL reads_per_line: got %0d want 160", reads3);
    else n_pass++;
    goto(790, 479);
    while (!(cx == 3 && cy == 480)) begin
      #3;
      if (cx == 0 && cy == 480) begin
        n_checks++;
        if (pixel_out !== 8'd0) $display("FAIL pixel_vblank: got %0h want 0", pixel_out);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_write_grant();
    int drops = 0;
    wr_valid_in = 1'b1;
    wr_x_in     = 8'd5;
    wr_y_in     = 7'd7;
    wr_color_in = 8'hAA;
    goto(0, 7);
    while (cy == 7) begin
      #3;
      if (!wr_ready_out) drops++;
      n_checks++;
      if (wr_ready_out !== !exp_read(cx, cy))
        $display("FAIL ready_slot @%0d: got %b want %b", cx, wr_ready_out, !exp_read(cx, cy));
      else n_pass++;
      if (cx == 11) begin
        n_checks++;
        if (fb_en_out !== 1'b1 || fb_we_out !== 1'b1 || fb_addr_out !== 16'h8465 ||
            fb_wdata_out !== 8'hAA)
          $display("FAIL write_port: en=%b we=%b addr=%0h data=%0h want 1 1 8465 aa",
                   fb_en_out, fb_we_out, fb_addr_out, fb_wdata_out);
        else n_pass++;
      end
      step();
    end
    n_checks++;
    if (drops != 160) $display("FAIL ready_drops: got %0d want 160", drops);
    else n_pass++;
  endtask

  task automatic test_swap();
    goto(96, 200);
    while (cx <= 200) begin
      swap_req_in = (cx == 100);
      #3;
      n_checks++;
      if (wr_ready_out !== ((cx <= 100) && !exp_read(cx, cy)))
        $display("FAIL swap_wait_ready @%0d: got %b", cx, wr_ready_out);
      else n_pass++;
      step();
    end
    swap_req_in = 1'b0;
    goto(796, 479);
    while (!(cx == 4 && cy == 480)) begin
      #3;
      if (cx == 0 && cy == 480) begin
        n_checks++;
        if (wr_ready_out !== 1'b0 || swap_done_out !== 1'b0 || front_buf_out !== 1'b0)
          $display("FAIL swap_pre: rdy=%b done=%b front=%b want 0 0 0",
                   wr_ready_out, swap_done_out, front_buf_out);
        else n_pass++;
      end else if (cx == 1 && cy == 480) begin
        n_checks++;
        if (wr_ready_out !== 1'b1 || swap_done_out !== 1'b1 || front_buf_out !== 1'b1)
          $display("FAIL swap_edge: rdy=%b done=%b front=%b want 1 1 1",
                   wr_ready_out, swap_done_out, front_buf_out);
        else n_pass++;
      end else if (cx == 2 && cy == 480) begin
        n_checks++;
        if (swap_done_out !== 1'b0) $display("FAIL swap_pulse_len: got %b want 0", swap_done_out);
        else n_pass++;
      end
      step();
    end
    goto(796, 524);
    while (!(cx == 1 && cy == 0)) begin
      #3;
      if (cx == 797) begin
        n_checks++;
        if (fb_we_out !== 1'b1 || fb_addr_out !== 16'h0465)
          $display("FAIL new_back_write: we=%b addr=%0h want 1 0465", fb_we_out, fb_addr_out);
        else n_pass++;
      end
      if (cx == 798) begin
        n_checks++;
        if (fb_en_out !== 1'b1 || fb_we_out !== 1'b0 || fb_addr_out !== 16'h8000)
          $display("FAIL new_front_read: en=%b we=%b addr=%0h want 1 0 8000",
                   fb_en_out, fb_we_out, fb_addr_out);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_reset_mid_swap();
    goto(96, 10);
    while (cx <= 160) begin
      swap_req_in = (cx == 100);
      rst_in      = (cx == 150);
      #3;
      if (cx > 150) begin
        n_checks++;
        if (front_buf_out !== 1'b0 || swap_done_out !== 1'b0 ||
            wr_ready_out !== !exp_read(cx, cy))
          $display("FAIL mid_swap_reset @%0d: front=%b done=%b rdy=%b want 0 0 %b", cx,
                   front_buf_out, swap_done_out, wr_ready_out, !exp_read(cx, cy));
        else n_pass++;
      end
      step();
    end
    swap_req_in = 1'b0;
    rst_in      = 1'b0;
    goto(796, 479);
    while (!(cx == 3 && cy == 480)) begin
      #3;
      n_checks++;
      if (swap_done_out !== 1'b0 || front_buf_out !== 1'b0)
        $display("FAIL no_swap_after_reset: done=%b front=%b want 0 0",
                 swap_done_out, front_buf_out);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_oob_late_swap();
    goto(20, 30);
    for (int i = 0; i < 8; i++) begin
      wr_x_in = (i % 2 == 0) ? 8'd160 : 8'd3;
      wr_y_in = (i % 2 == 0) ? 7'd3 : 7'd120;
      #3;
      n_checks++;
      if (exp_read(cx, cy)) begin
        if (fb_en_out !== 1'b1 || fb_we_out !== 1'b0)
          $display("FAIL oob_slot: en=%b we=%b want 1 0", fb_en_out, fb_we_out);
        else n_pass++;
      end else begin
        if (wr_ready_out !== 1'b1 || fb_en_out !== 1'b0)
          $display("FAIL oob_drop: rdy=%b en=%b want 1 0", wr_ready_out, fb_en_out);
        else n_pass++;
      end
      step();
    end
    wr_x_in = 8'd5;
    wr_y_in = 7'd7;
    goto(0, 481);
    while (cx <= 10) begin
      swap_req_in = (cx == 0);
      #3;
      n_checks++;
      if (swap_done_out !== 1'b0 || front_buf_out !== 1'b0 ||
          wr_ready_out !== (cx == 0))
        $display("FAIL late_req @%0d: done=%b front=%b rdy=%b", cx,
                 swap_done_out, front_buf_out, wr_ready_out);
      else n_pass++;
      step();
    end
    swap_req_in = 1'b0;
    goto(796, 479);
    while (!(cx == 3 && cy == 480)) begin
      #3;
      if (cx == 1 && cy == 480) begin
        n_checks++;
        if (swap_done_out !== 1'b1 || front_buf_out !== 1'b1)
          $display("FAIL late_swap: done=%b front=%b want 1 1", swap_done_out, front_buf_out);
        else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int w = 0; w < 8; w++) begin
      if (w % 2 == 1) goto(600 + int'($urandom_range(0, 199)), 479);
      else goto(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
      for (int i = 0; i < 400; i++) begin
        bit       e_rdy, e_en, e_we, inr;
        logic [15:0] e_addr;
        wr_valid_in = 1'($urandom_range(0, 1));
        wr_x_in     = ($urandom_range(0, 7) == 0) ? 8'(160 + $urandom_range(0, 95))
                                                  : 8'($urandom_range(0, 159));
        wr_y_in     = ($urandom_range(0, 7) == 0) ? 7'(120 + $urandom_range(0, 7))
                                                  : 7'($urandom_range(0, 119));
        wr_color_in = 8'($urandom);
        swap_req_in = ($urandom_range(0, 63) == 0);
        #3;
        inr    = (wr_x_in < 160) && (wr_y_in < 120);
        e_rdy  = !m_wait && !exp_read(cx, cy);
        e_en   = exp_read(cx, cy) || (wr_valid_in && e_rdy && inr);
        e_we   = !exp_read(cx, cy) && e_en;
        e_addr = exp_read(cx, cy) ? exp_raddr(m_front, cx, cy)
                                  : {!m_front, 15'(int'(wr_y_in) * 160 + int'(wr_x_in))};
        n_checks++;
        if (wr_ready_out !== e_rdy || fb_en_out !== e_en || fb_we_out !== e_we ||
            (e_en && fb_addr_out !== e_addr) || (e_we && fb_wdata_out !== wr_color_in))
          $display("FAIL rand_port @%0d,%0d: rdy=%b en=%b we=%b addr=%0h want %b %b %b %0h",
                   cx, cy, wr_ready_out, fb_en_out, fb_we_out, fb_addr_out,
                   e_rdy, e_en, e_we, e_addr);
        else n_pass++;
        n_checks++;
        if (swap_done_out !== m_done || front_buf_out !== m_front)
          $display("FAIL rand_swap @%0d,%0d: done=%b front=%b want %b %b", cx, cy,
                   swap_done_out, front_buf_out, m_done, m_front);
        else n_pass++;
        if (i >= 6) begin
          n_checks++;
          if (pixel_out !== exp_pixel(cx, cy))
            $display("FAIL rand_pixel @%0d,%0d: got %0d want %0d", cx, cy, pixel_out,
                     exp_pixel(cx, cy));
          else n_pass++;
        end
        step();
      end
    end
    swap_req_in = 1'b0;
    wr_valid_in = 1'b0;
  endtask

  initial begin
    rst_in      = 1'b1;
    wr_valid_in = 1'b0;
    wr_x_in     = '0;
    wr_y_in     = '0;
    wr_color_in = '0;
    swap_req_in = 1'b0;
    m_front     = 1'b0;
    m_wait      = 1'b0;
    m_done      = 1'b0;
    goto(0, 0);
    @(posedge clk_in);
    #1;
    test_reset();
    test_pixels();
    test_write_grant();
    test_swap();
    test_reset_mid_swap();
    test_oob_late_swap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
